// File: rtl/mem_channel_arbiter_if.sv
// Valid/ready bundle between the requesters, mem_channel_arbiter and the data memory.
// master is the arbiter's view; slave is the requesters plus memory around it.
interface mem_channel_arbiter_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 16,
  parameter int NUM_CHANNELS  = 4
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

  logic [NUM_CHANNELS-1:0]            mem_read_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]            mem_read_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]            mem_write_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]            mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    output consumer_read_ready, consumer_read_data,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_write_ready,
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    input  consumer_read_ready, consumer_read_data,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/mem_channel_arbiter.sv
// Shares NUM_CHANNELS data-memory channels among NUM_CONSUMERS LSU requesters.
// Each channel runs its own transaction FSM and grants requesters round-robin.
//
//   state       | meaning
//   IDLE        | scanning requesters from rr_ptr for an unclaimed valid one
//   READ_WAIT   | mem_read_valid held, waiting for mem_read_ready
//   WRITE_WAIT  | mem_write_valid held, waiting for mem_write_ready
//   READ_RELAY  | consumer_read_ready held until the requester drops read_valid
//   WRITE_RELAY | consumer_write_ready held until the requester drops write_valid
module mem_channel_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 16,
  parameter int NUM_CHANNELS  = 4,
  parameter bit WRITE_ENABLE  = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  mem_channel_arbiter_if.master bus
);
  localparam int AB  = ADDR_BITS;
  localparam int DB  = DATA_BITS;
  localparam int NC  = NUM_CONSUMERS;
  localparam int NCH = NUM_CHANNELS;
  localparam int IW  = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } state_t;

  state_t        state  [NCH];
  logic [IW-1:0] rr_ptr [NCH];
  logic [IW-1:0] owner  [NCH];
  logic [NC-1:0] claim;

  logic [NC-1:0] read_req;
  logic [NC-1:0] write_req;

  // A read-only instance never sees write requests, so the write states stay unreachable.
  assign read_req  = bus.consumer_read_valid;
  assign write_req = WRITE_ENABLE ? bus.consumer_write_valid : '0;

  logic [NCH-1:0] grant;
  logic [NCH-1:0] grant_read;
  logic [IW-1:0]  grant_idx [NCH];
  logic [NC-1:0]  taken;
  logic [IW-1:0]  scan_idx;
  int             scan_sum;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == IW'(NC - 1)) ? '0 : p + IW'(1);
  endfunction

  // Channels are resolved in index order so a lower channel's claim blocks higher ones this cycle.
  always_comb begin
    taken      = claim;
    grant      = '0;
    grant_read = '0;
    scan_idx   = '0;
    scan_sum   = 0;
    for (int c = 0; c < NCH; c++) begin
      grant_idx[c] = '0;
      if (state[c] == IDLE) begin
        for (int k = 0; k < NC; k++) begin
          scan_sum = int'(rr_ptr[c]) + k;
          if (scan_sum >= NC) scan_sum = scan_sum - NC;
          scan_idx = IW'(scan_sum);
          if (!grant[c] && !taken[scan_idx] && (read_req[scan_idx] || write_req[scan_idx])) begin
            grant[c]      = 1'b1;
            grant_idx[c]  = scan_idx;
            grant_read[c] = read_req[scan_idx];
          end
        end
        if (grant[c]) taken[grant_idx[c]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      claim                    <= '0;
      bus.consumer_read_ready  <= '0;
      bus.consumer_read_data   <= '0;
      bus.consumer_write_ready <= '0;
      bus.mem_read_valid       <= '0;
      bus.mem_read_address     <= '0;
      bus.mem_write_valid      <= '0;
      bus.mem_write_address    <= '0;
      bus.mem_write_data       <= '0;
      for (int c = 0; c < NCH; c++) begin
        state[c]  <= IDLE;
        rr_ptr[c] <= '0;
        owner[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        case (state[c])
          IDLE: begin
            if (grant[c]) begin
              claim[grant_idx[c]] <= 1'b1;
              owner[c]            <= grant_idx[c];
              rr_ptr[c]           <= next_ptr(grant_idx[c]);
              if (grant_read[c]) begin
                bus.mem_read_valid[c]            <= 1'b1;
                bus.mem_read_address[c*AB +: AB] <=
                  bus.consumer_read_address[grant_idx[c]*AB +: AB];
                state[c]                         <= READ_WAIT;
              end else begin
                bus.mem_write_valid[c]            <= 1'b1;
                bus.mem_write_address[c*AB +: AB] <=
                  bus.consumer_write_address[grant_idx[c]*AB +: AB];
                bus.mem_write_data[c*DB +: DB]    <=
                  bus.consumer_write_data[grant_idx[c]*DB +: DB];
                state[c]                          <= WRITE_WAIT;
              end
            end
          end
          READ_WAIT: begin
            if (bus.mem_read_ready[c]) begin
              bus.consumer_read_data[owner[c]*DB +: DB] <= bus.mem_read_data[c*DB +: DB];
              bus.consumer_read_ready[owner[c]]         <= 1'b1;
              bus.mem_read_valid[c]                     <= 1'b0;
              state[c]                                  <= READ_RELAY;
            end
          end
          WRITE_WAIT: begin
            if (bus.mem_write_ready[c]) begin
              bus.consumer_write_ready[owner[c]] <= 1'b1;
              bus.mem_write_valid[c]             <= 1'b0;
              state[c]                           <= WRITE_RELAY;
            end
          end
          // The claim is released on the same edge as ready, so a regrant can only follow a cycle later.
          READ_RELAY: begin
            if (!read_req[owner[c]]) begin
              bus.consumer_read_ready[owner[c]] <= 1'b0;
              claim[owner[c]]                   <= 1'b0;
              state[c]                          <= IDLE;
            end
          end
          WRITE_RELAY: begin
            if (!write_req[owner[c]]) begin
              bus.consumer_write_ready[owner[c]] <= 1'b0;
              claim[owner[c]]                    <= 1'b0;
              state[c]                           <= IDLE;
            end
          end
          default: state[c] <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Self-checking bench for mem_channel_arbiter: directed vector table, hand sequences,
// then random requesters and memory checked against a transaction-level reference model.
module tb_mem_channel_arbiter;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NC  = 16;
  localparam int NCH = 4;

  localparam int S_IDLE     = 0;
  localparam int S_RD_WAIT  = 1;
  localparam int S_WR_WAIT  = 2;
  localparam int S_RD_RELAY = 3;
  localparam int S_WR_RELAY = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_channel_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB),
                           .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) bus ();

  mem_channel_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH),
    .WRITE_ENABLE(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DB-1:0] mem_arr [256];

  // Reference model: each channel is a transaction slot with an owner and a round-robin pointer.
  int m_ph   [NCH];
  int m_own  [NCH];
  int m_ptr  [NCH];
  int m_addr [NCH];
  int m_wdat [NCH];
  bit m_claim [NC];
  bit m_rrdy  [NC];
  bit m_wrdy  [NC];
  int m_rdat  [NC];

  typedef struct {
    logic          rv0;
    logic [AB-1:0] ra0;
    logic          mrr0;
    logic [DB-1:0] mrd0;
    logic          e_mrv0;
    logic [AB-1:0] e_ma0;
    logic          e_rr0;
    logic [DB-1:0] e_rd0;
  } vec_t;
  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
    bus.mem_read_ready         = '0;
    bus.mem_read_data          = '0;
    bus.mem_write_ready        = '0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ph[c] = S_IDLE; m_own[c] = 0; m_ptr[c] = 0; m_addr[c] = 0; m_wdat[c] = 0;
    end
    for (int i = 0; i < NC; i++) begin
      m_claim[i] = 1'b0; m_rrdy[i] = 1'b0; m_wrdy[i] = 1'b0; m_rdat[i] = 0;
    end
  endtask

  task automatic model_step();
    bit taken [NC];
    bit found;
    int i;
    if (!reset) begin
      model_reset();
      return;
    end
    taken = m_claim;
    for (int c = 0; c < NCH; c++) begin
      case (m_ph[c])
        S_IDLE: begin
          found = 1'b0;
          for (int k = 0; k < NC; k++) begin
            i = (m_ptr[c] + k) % NC;
            if (!found && !taken[i] &&
                (bus.consumer_read_valid[i] || bus.consumer_write_valid[i])) begin
              found      = 1'b1;
              taken[i]   = 1'b1;
              m_claim[i] = 1'b1;
              m_own[c]   = i;
              m_ptr[c]   = (i + 1) % NC;
              if (bus.consumer_read_valid[i]) begin
                m_ph[c]   = S_RD_WAIT;
                m_addr[c] = int'(bus.consumer_read_address[i*AB +: AB]);
              end else begin
                m_ph[c]   = S_WR_WAIT;
                m_addr[c] = int'(bus.consumer_write_address[i*AB +: AB]);
                m_wdat[c] = int'(bus.consumer_write_data[i*DB +: DB]);
              end
            end
          end
        end
        S_RD_WAIT: if (bus.mem_read_ready[c]) begin
          m_rdat[m_own[c]] = int'(bus.mem_read_data[c*DB +: DB]);
          m_rrdy[m_own[c]] = 1'b1;
          m_ph[c]          = S_RD_RELAY;
        end
        S_WR_WAIT: if (bus.mem_write_ready[c]) begin
          m_wrdy[m_own[c]] = 1'b1;
          m_ph[c]          = S_WR_RELAY;
        end
        S_RD_RELAY: if (!bus.consumer_read_valid[m_own[c]]) begin
          m_rrdy[m_own[c]]  = 1'b0;
          m_claim[m_own[c]] = 1'b0;
          m_ph[c]           = S_IDLE;
        end
        S_WR_RELAY: if (!bus.consumer_write_valid[m_own[c]]) begin
          m_wrdy[m_own[c]]  = 1'b0;
          m_claim[m_own[c]] = 1'b0;
          m_ph[c]           = S_IDLE;
        end
        default: ;
      endcase
    end
  endtask

  task automatic model_compare();
    logic [NCH-1:0] e_mrv;
    logic [NCH-1:0] e_mwv;
    logic [NC-1:0]  e_rr;
    logic [NC-1:0]  e_wr;
    for (int c = 0; c < NCH; c++) begin
      e_mrv[c] = (m_ph[c] == S_RD_WAIT);
      e_mwv[c] = (m_ph[c] == S_WR_WAIT);
    end
    for (int i = 0; i < NC; i++) begin
      e_rr[i] = m_rrdy[i];
      e_wr[i] = m_wrdy[i];
    end
    check("rnd_mem_read_valid",  32'(bus.mem_read_valid),  32'(e_mrv));
    check("rnd_mem_write_valid", 32'(bus.mem_write_valid), 32'(e_mwv));
    check("rnd_read_ready",      32'(bus.consumer_read_ready),  32'(e_rr));
    check("rnd_write_ready",     32'(bus.consumer_write_ready), 32'(e_wr));
    for (int c = 0; c < NCH; c++) begin
      if (e_mrv[c])
        check($sformatf("rnd_mem_read_address[%0d]", c),
              32'(bus.mem_read_address[c*AB +: AB]), 32'(m_addr[c]));
      if (e_mwv[c]) begin
        check($sformatf("rnd_mem_write_address[%0d]", c),
              32'(bus.mem_write_address[c*AB +: AB]), 32'(m_addr[c]));
        check($sformatf("rnd_mem_write_data[%0d]", c),
              32'(bus.mem_write_data[c*DB +: DB]), 32'(m_wdat[c]));
      end
    end
    for (int i = 0; i < NC; i++)
      check($sformatf("rnd_read_data[%0d]", i),
            32'(bus.consumer_read_data[i*DB +: DB]), 32'(m_rdat[i]));
  endtask

  task automatic drive_random();
    for (int i = 0; i < NC; i++) begin
      if (bus.consumer_read_valid[i]) begin
        if (bus.consumer_read_ready[i] || $urandom_range(0, 63) == 0)
          bus.consumer_read_valid[i] = 1'b0;
      end else if (!bus.consumer_read_ready[i] && $urandom_range(0, 3) == 0) begin
        bus.consumer_read_valid[i]          = 1'b1;
        bus.consumer_read_address[i*AB +: AB] = AB'($urandom);
      end
      if (bus.consumer_write_valid[i]) begin
        if (bus.consumer_write_ready[i] || $urandom_range(0, 63) == 0)
          bus.consumer_write_valid[i] = 1'b0;
      end else if (!bus.consumer_write_ready[i] && $urandom_range(0, 5) == 0) begin
        bus.consumer_write_valid[i]            = 1'b1;
        bus.consumer_write_address[i*AB +: AB] = AB'($urandom);
        bus.consumer_write_data[i*DB +: DB]    = DB'($urandom);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (bus.mem_read_valid[c] && $urandom_range(0, 2) == 0) begin
        bus.mem_read_ready[c]         = 1'b1;
        bus.mem_read_data[c*DB +: DB] = mem_arr[bus.mem_read_address[c*AB +: AB]];
      end else begin
        bus.mem_read_ready[c]         = 1'b0;
        bus.mem_read_data[c*DB +: DB] = DB'($urandom);
      end
      if (bus.mem_write_valid[c] && $urandom_range(0, 2) == 0) begin
        bus.mem_write_ready[c] = 1'b1;
        mem_arr[bus.mem_write_address[c*AB +: AB]] = bus.mem_write_data[c*DB +: DB];
      end else begin
        bus.mem_write_ready[c] = 1'b0;
      end
    end
  endtask

  initial begin
    // Requester 0 reads 0x05; memory answers 0x2A on the fourth cycle, then the requester lets go.
    vt[0] = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 8'h00};
    vt[1] = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 8'h00};
    vt[2] = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 8'h00};
    vt[3] = '{1'b1, 8'h05, 1'b1, 8'h2A, 1'b0, 8'h05, 1'b1, 8'h2A};
    vt[4] = '{1'b1, 8'h05, 1'b0, 8'h77, 1'b0, 8'h05, 1'b1, 8'h2A};
    vt[5] = '{1'b0, 8'h05, 1'b0, 8'h00, 1'b0, 8'h05, 1'b0, 8'h2A};
    vt[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h05, 1'b0, 8'h2A};

    for (int a = 0; a < 256; a++) mem_arr[a] = DB'($urandom);

    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read_valid",   32'(bus.mem_read_valid), 32'd0);
    check("rst_mem_write_valid",  32'(bus.mem_write_valid), 32'd0);
    check("rst_read_ready",       32'(bus.consumer_read_ready), 32'd0);
    check("rst_write_ready",      32'(bus.consumer_write_ready), 32'd0);
    check("rst_read_data_nonzero", 32'(bus.consumer_read_data != '0), 32'd0);
    reset = 1'b1;

    for (int r = 0; r < 7; r++) begin
      bus.consumer_read_valid[0]     = vt[r].rv0;
      bus.consumer_read_address[7:0] = vt[r].ra0;
      bus.mem_read_ready[0]          = vt[r].mrr0;
      bus.mem_read_data[7:0]         = vt[r].mrd0;
      tick();
      check($sformatf("vec%0d_mem_read_valid", r), 32'(bus.mem_read_valid), 32'(vt[r].e_mrv0));
      if (vt[r].e_mrv0)
        check($sformatf("vec%0d_mem_read_address", r), 32'(bus.mem_read_address[7:0]), 32'(vt[r].e_ma0));
      check($sformatf("vec%0d_read_ready", r), 32'(bus.consumer_read_ready), 32'(vt[r].e_rr0));
      check($sformatf("vec%0d_read_data0", r), 32'(bus.consumer_read_data[7:0]), 32'(vt[r].e_rd0));
    end

    // Requester 2 asks for a read and a write together: read first, write on a later grant.
    bus.consumer_read_valid[2]         = 1'b1;
    bus.consumer_read_address[23:16]   = 8'h33;
    bus.consumer_write_valid[2]        = 1'b1;
    bus.consumer_write_address[23:16]  = 8'h44;
    bus.consumer_write_data[23:16]     = 8'h99;
    tick();
    check("rw_read_granted",   32'(bus.mem_read_valid), 32'h1);
    check("rw_read_address",   32'(bus.mem_read_address[7:0]), 32'h33);
    check("rw_no_write_yet",   32'(bus.mem_write_valid), 32'h0);
    bus.mem_read_ready[0] = 1'b1;
    bus.mem_read_data[7:0] = 8'h5C;
    tick();
    check("rw_read_ready",     32'(bus.consumer_read_ready), 32'h4);
    check("rw_read_data",      32'(bus.consumer_read_data[23:16]), 32'h5C);
    check("rw_write_blocked",  32'(bus.mem_write_valid), 32'h0);
    bus.mem_read_ready[0]      = 1'b0;
    bus.consumer_read_valid[2] = 1'b0;
    tick();
    check("rw_read_ready_drop", 32'(bus.consumer_read_ready), 32'h0);
    check("rw_no_same_edge_regrant", 32'(bus.mem_write_valid), 32'h0);
    tick();
    check("rw_write_granted",  32'(bus.mem_write_valid), 32'h1);
    check("rw_write_address",  32'(bus.mem_write_address[7:0]), 32'h44);
    check("rw_write_data",     32'(bus.mem_write_data[7:0]), 32'h99);
    check("rw_write_ready_early", 32'(bus.consumer_write_ready), 32'h0);
    bus.mem_write_ready[0] = 1'b1;
    tick();
    check("rw_write_ready",    32'(bus.consumer_write_ready), 32'h4);
    check("rw_write_valid_drop", 32'(bus.mem_write_valid), 32'h0);
    bus.mem_write_ready[0]      = 1'b0;
    bus.consumer_write_valid[2] = 1'b0;
    tick();
    check("rw_write_ready_drop", 32'(bus.consumer_write_ready), 32'h0);
    check("rw_read_data_held", 32'(bus.consumer_read_data[23:16]), 32'h5C);

    // Reset lands while channel 0 waits on memory; afterwards pointers restart at 0.
    bus.consumer_read_valid[5]       = 1'b1;
    bus.consumer_read_address[47:40] = 8'h10;
    tick();
    check("mid_read_granted", 32'(bus.mem_read_valid), 32'h1);
    check("mid_read_address", 32'(bus.mem_read_address[7:0]), 32'h10);
    reset = 1'b0;
    tick();
    check("mid_rst_mem_read_valid",   32'(bus.mem_read_valid), 32'h0);
    check("mid_rst_mem_read_address", 32'(bus.mem_read_address[7:0]), 32'h0);
    check("mid_rst_read_ready",       32'(bus.consumer_read_ready), 32'h0);
    check("mid_rst_read_data0",       32'(bus.consumer_read_data[7:0]), 32'h0);
    check("mid_rst_read_data2",       32'(bus.consumer_read_data[23:16]), 32'h0);
    reset = 1'b1;
    bus.consumer_read_valid[5]       = 1'b0;
    bus.consumer_read_valid[4]       = 1'b1;
    bus.consumer_read_address[39:32] = 8'h4A;
    bus.consumer_read_valid[7]       = 1'b1;
    bus.consumer_read_address[63:56] = 8'h7B;
    tick();
    check("post_rst_grants",   32'(bus.mem_read_valid), 32'h3);
    check("post_rst_ch0_addr", 32'(bus.mem_read_address[7:0]), 32'h4A);
    check("post_rst_ch1_addr", 32'(bus.mem_read_address[15:8]), 32'h7B);

    clear_inputs();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc < 2) reset = 1'b0;
      else reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      drive_random();
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_compare();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
